// File: rtl/edge_stream_pkg.sv
// Shared types for the edge-stream packing path: pixel type, per-word framing
// flags, output FSM encoding and the binarize rule applied at pop time.
package edge_stream_pkg;

  localparam int PIXEL_W      = 8;
  localparam int PACK_DEFAULT = 4;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } word_flags_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Unsigned threshold: at or above the threshold saturates to all-ones.
  function automatic pixel_t binarize(pixel_t p, pixel_t th, logic en);
    if (!en) return p;
    return (p >= th) ? {PIXEL_W{1'b1}} : {PIXEL_W{1'b0}};
  endfunction

endpackage

// File: rtl/raster_pos_counter.sv
// Raster column/row position tracker; advances one pixel per pulse and wraps
// at the end of each row and frame.
module raster_pos_counter #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540,
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             is_first,
  output logic             is_last_col,
  output logic             is_last_row
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

  assign is_first    = (col == '0) && (row == '0);
  assign is_last_col = (col == LAST_COL);
  assign is_last_row = (row == LAST_ROW);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (is_last_col) begin
        col <= '0;
        row <= is_last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/edge_stream_packer.sv
// Drains single-pixel results from a show-ahead FIFO, optionally binarizes
// them, and packs PACK pixels per word onto a valid/ready port with raster flags.
module edge_stream_packer
  import edge_stream_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int IMAGE_WIDTH  = 720,
  parameter int IMAGE_HEIGHT = 540,
  parameter int PACK         = PACK_DEFAULT,
  localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1,
  localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_empty,
  input  logic [DATA_WIDTH-1:0]      in_dout,
  output logic                       in_rd_en,
  input  logic                       bin_en,
  input  logic [DATA_WIDTH-1:0]      threshold,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic                       out_sof,
  output logic                       out_eol,
  output logic                       out_eof,
  output logic                       frame_done,
  output out_state_e                 dbg_state,
  output logic [COL_W-1:0]           dbg_col,
  output logic [ROW_W-1:0]           dbg_row
);

  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);

  generate
    if (IMAGE_WIDTH % PACK != 0) begin : g_bad_width
      $error("IMAGE_WIDTH must be a multiple of PACK");
    end
    if (PACK < 2) begin : g_bad_pack
      $error("PACK must be at least 2");
    end
  endgenerate

  // Handshakes: a FIFO pop happens on any edge where in_rd_en=1 (in_dout is the
  // popped pixel); a word transfers on any edge where out_valid && out_ready.
  // out_valid never drops and out_data/flags never change until the transfer.
  logic                  pop, accept, complete, stall;
  logic [LANE_W-1:0]     lane_idx_q;
  logic [DATA_WIDTH-1:0] lane_q [PACK-1];
  logic [DATA_WIDTH-1:0] pix_in;
  logic                  sof_pend_q;
  logic                  pos_first, pos_last_col, pos_last_row;
  logic [DATA_WIDTH*PACK-1:0] word_next;
  word_flags_t           flags_next, out_flags_q;
  out_state_e            state_q, state_d;

  assign stall    = out_valid && !out_ready && (lane_idx_q == LAST_LANE);
  assign in_rd_en = !in_empty && !stall && rst;
  assign pop      = in_rd_en;
  assign accept   = out_valid && out_ready;
  assign complete = pop && (lane_idx_q == LAST_LANE);

  generate
    if (DATA_WIDTH == PIXEL_W) begin : g_pkg_bin
      assign pix_in = binarize(in_dout, threshold, bin_en);
    end else begin : g_wide_bin
      assign pix_in = !bin_en ? in_dout :
                      (in_dout >= threshold) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
    end
  endgenerate

  raster_pos_counter #(
    .WIDTH  (IMAGE_WIDTH),
    .HEIGHT (IMAGE_HEIGHT)
  ) u_pos (
    .clk         (clk),
    .rst         (rst),
    .advance     (pop),
    .col         (dbg_col),
    .row         (dbg_row),
    .is_first    (pos_first),
    .is_last_col (pos_last_col),
    .is_last_row (pos_last_row)
  );

  // The last lane never sits in the pack register; it goes straight into the word.
  always_comb begin
    word_next = '0;
    for (int i = 0; i < PACK - 1; i++) begin
      word_next[i*DATA_WIDTH +: DATA_WIDTH] = lane_q[i];
    end
    word_next[(PACK-1)*DATA_WIDTH +: DATA_WIDTH] = pix_in;
    flags_next.sof = sof_pend_q;
    flags_next.eol = pos_last_col;
    flags_next.eof = pos_last_col && pos_last_row;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_idx_q <= '0;
      sof_pend_q <= 1'b0;
      for (int i = 0; i < PACK - 1; i++) lane_q[i] <= '0;
    end else if (pop) begin
      lane_idx_q <= (lane_idx_q == LAST_LANE) ? '0 : lane_idx_q + 1'b1;
      for (int i = 0; i < PACK - 1; i++) begin
        if (lane_idx_q == LANE_W'(i)) lane_q[i] <= pix_in;
      end
      if (lane_idx_q == '0) sof_pend_q <= pos_first;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= OUT_EMPTY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_EMPTY: if (complete) state_d = OUT_FULL;
      OUT_FULL:  if (accept && !complete) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
  end

  assign out_valid = (state_q == OUT_FULL);
  assign dbg_state = state_q;

  // A completion while FULL implies the old word is being accepted this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data    <= '0;
      out_flags_q <= '0;
      frame_done  <= 1'b0;
    end else begin
      if (complete) begin
        out_data    <= word_next;
        out_flags_q <= flags_next;
      end
      frame_done <= accept && out_flags_q.eof;
    end
  end

  assign out_sof = out_flags_q.sof;
  assign out_eol = out_flags_q.eol;
  assign out_eof = out_flags_q.eof;

endmodule

// File: tb/tb_edge_stream_packer.sv
// Bench for edge_stream_packer on an 8x2 image, PACK=4: source FIFO model,
// per-pop pixel model, and expected words rebuilt from raster pixel indices.
module tb_edge_stream_packer;
  import edge_stream_pkg::*;

  localparam int W = 8;
  localparam int H = 2;
  localparam int P = 4;
  localparam int FRAME = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_empty = 1'b1;
  logic [7:0]  in_dout = 8'h00;
  logic        in_rd_en;
  logic        bin_en = 1'b0;
  logic [7:0]  threshold = 8'h80;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_sof, out_eol, out_eof, frame_done;
  out_state_e  dbg_state;
  logic [2:0]  dbg_col;
  logic [0:0]  dbg_row;

  edge_stream_packer #(
    .DATA_WIDTH(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PACK(P)
  ) dut (
    .clk(clk), .rst(rst), .in_empty(in_empty), .in_dout(in_dout),
    .in_rd_en(in_rd_en), .bin_en(bin_en), .threshold(threshold),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .frame_done(frame_done), .dbg_state(dbg_state),
    .dbg_col(dbg_col), .dbg_row(dbg_row)
  );

  always #5 clk = ~clk;

  // word layout in the queues: {eof, eol, sof, data[31:0]}
  logic [7:0]  src_q[$];
  logic [7:0]  mpix_q[$];
  logic [34:0] got_q[$];
  logic [34:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc, pops, rd_when_empty, unstable, fd_count, fd_cyc, eof_acc_cyc;
  int first_pop_cyc, last_pop_cyc;
  logic        prev_stall;
  logic [34:0] prev_word;

  function automatic logic [7:0] ref_pixel(logic [7:0] p, logic [7:0] th, logic en);
    if (!en) return p;
    return (p >= th) ? 8'hFF : 8'h00;
  endfunction

  // Word k holds pixels 4k..4k+3 counted from reset; positions follow from the index.
  function automatic void build_exp();
    exp_q.delete();
    for (int k = 0; k < mpix_q.size() / P; k++) begin
      logic [31:0] d;
      int n0, n3;
      logic sof, eol, eof;
      d = '0;
      for (int l = 0; l < P; l++) d[l*8 +: 8] = mpix_q[k*P + l];
      n0 = k * P;
      n3 = k * P + P - 1;
      sof = (n0 % FRAME) == 0;
      eol = (n3 % W) == W - 1;
      eof = eol && (((n3 / W) % H) == H - 1);
      exp_q.push_back({eof, eol, sof, d});
    end
  endfunction

  function automatic void clear_obs();
    src_q.delete(); mpix_q.delete(); got_q.delete(); exp_q.delete();
    cyc = 0; pops = 0; rd_when_empty = 0; unstable = 0; fd_count = 0;
    fd_cyc = -1; eof_acc_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
    prev_stall = 1'b0; prev_word = '0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; in_empty = 1'b1; out_ready = 1'b0; bin_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_obs();
  endtask

  // One clock: observe last edge's outputs, drive inputs, record the upcoming pop/accept.
  task automatic step(input logic bubble, input logic rdy, input logic ben);
    logic [34:0] cur;
    @(negedge clk);
    cyc++;
    cur = {out_eof, out_eol, out_sof, out_data};
    if (frame_done) begin fd_count++; fd_cyc = cyc; end
    if (prev_stall && cur !== prev_word) unstable++;
    in_empty  = bubble || (src_q.size() == 0);
    in_dout   = (src_q.size() != 0) ? src_q[0] : 8'h00;
    out_ready = rdy;
    bin_en    = ben;
    #1;
    if (in_rd_en && in_empty) rd_when_empty++;
    if (in_rd_en) begin
      mpix_q.push_back(ref_pixel(in_dout, threshold, bin_en));
      void'(src_q.pop_front());
      pops++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      got_q.push_back(cur);
      if (out_eof) eof_acc_cyc = cyc;
    end
    prev_stall = out_valid && !out_ready;
    prev_word  = cur;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_empty = 1'b0; in_dout = 8'hAA; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (in_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", in_rd_en); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
    total++; if ({out_eof, out_eol, out_sof, out_data} !== 35'h0) begin
      bad++; $display("FAIL reset_word got=%h want=0", {out_eof, out_eol, out_sof, out_data});
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (in_rd_en !== 1'b1) begin bad++; $display("FAIL reset_first_pop got=%b want=1", in_rd_en); end
    in_empty = 1'b1;
    clear_obs();
  endtask

  task automatic test_streaming();
    do_reset();
    for (int i = 1; i <= 16; i++) src_q.push_back(8'(i));
    repeat (24) step(1'b0, 1'b1, 1'b0);
    build_exp();
    total++; if (pops !== 16) begin bad++; $display("FAIL stream_pops got=%0d want=16", pops); end
    total++; if (last_pop_cyc - first_pop_cyc !== 15) begin
      bad++; $display("FAIL stream_consecutive got=%0d want=15", last_pop_cyc - first_pop_cyc);
    end
    total++; if (got_q.size() !== 4) begin bad++; $display("FAIL stream_count got=%0d want=4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL stream_word%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() == 4) begin
      total++; if (got_q[0] !== {3'b001, 32'h04030201}) begin bad++; $display("FAIL stream_first got=%h want=%h", got_q[0], {3'b001, 32'h04030201}); end
      total++; if (got_q[3] !== {3'b110, 32'h100F0E0D}) begin bad++; $display("FAIL stream_last got=%h want=%h", got_q[3], {3'b110, 32'h100F0E0D}); end
    end
    total++; if (fd_count !== 1) begin bad++; $display("FAIL stream_fd_count got=%0d want=1", fd_count); end
    total++; if (fd_cyc !== eof_acc_cyc + 1) begin bad++; $display("FAIL stream_fd_timing got=%0d want=%0d", fd_cyc, eof_acc_cyc + 1); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 1; i <= 16; i++) src_q.push_back(8'(i));
    repeat (12) step(1'b0, 1'b0, 1'b0);
    total++; if (pops !== 7) begin bad++; $display("FAIL bp_pops got=%0d want=7", pops); end
    total++; if (in_rd_en !== 1'b0) begin bad++; $display("FAIL bp_rd_en got=%b want=0", in_rd_en); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b want=1", out_valid); end
    repeat (20) step(1'b0, 1'b1, 1'b0);
    build_exp();
    total++; if (unstable !== 0) begin bad++; $display("FAIL bp_stable got=%0d want=0", unstable); end
    total++; if (got_q.size() !== 4) begin bad++; $display("FAIL bp_count got=%0d want=4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_word%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_bubbles();
    do_reset();
    for (int i = 1; i <= 16; i++) src_q.push_back(8'(i));
    for (int i = 0; i < 40; i++) step(i[0], 1'b1, 1'b0);
    build_exp();
    total++; if (rd_when_empty !== 0) begin bad++; $display("FAIL bub_rd_empty got=%0d want=0", rd_when_empty); end
    total++; if (got_q.size() !== 4) begin bad++; $display("FAIL bub_count got=%0d want=4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bub_word%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() > 1) begin
      total++; if (got_q[1] !== {3'b010, 32'h08070605}) begin bad++; $display("FAIL bub_eol_word got=%h want=%h", got_q[1], {3'b010, 32'h08070605}); end
    end
  endtask

  task automatic test_binarize();
    do_reset();
    threshold = 8'h80;
    src_q = '{8'h7F, 8'h80, 8'h81, 8'h00};
    repeat (8) step(1'b0, 1'b1, 1'b1);
    total++; if (got_q.size() !== 1) begin bad++; $display("FAIL bin_count got=%0d want=1", got_q.size()); end
    if (got_q.size() > 0) begin
      total++; if (got_q[0] !== {3'b001, 32'h00FFFF00}) begin bad++; $display("FAIL bin_word got=%h want=%h", got_q[0], {3'b001, 32'h00FFFF00}); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 1; i <= 6; i++) src_q.push_back(8'(i));
    repeat (8) step(1'b0, 1'b1, 1'b0);
    #2 rst = 1'b0;
    in_empty = 1'b1;
    @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", out_valid); end
    @(negedge clk);
    rst = 1'b1;
    clear_obs();
    src_q = '{8'h21, 8'h22, 8'h23, 8'h24};
    repeat (10) step(1'b0, 1'b1, 1'b0);
    total++; if (got_q.size() !== 1) begin bad++; $display("FAIL mid_count got=%0d want=1", got_q.size()); end
    if (got_q.size() > 0) begin
      total++; if (got_q[0] !== {3'b001, 32'h24232221}) begin bad++; $display("FAIL mid_word got=%h want=%h", got_q[0], {3'b001, 32'h24232221}); end
    end
  endtask

  task automatic test_back_to_back();
    int guard;
    do_reset();
    threshold = 8'($urandom_range(0, 255));
    for (int i = 0; i < 3 * FRAME; i++) src_q.push_back(8'($urandom_range(0, 255)));
    guard = 0;
    while (got_q.size() < 3 * FRAME / P && guard < 3000) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)));
      guard++;
    end
    repeat (3) step(1'b1, 1'b1, 1'b0);
    build_exp();
    total++; if (got_q.size() !== 3 * FRAME / P) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", got_q.size(), 3 * FRAME / P); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_word%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (fd_count !== 3) begin bad++; $display("FAIL b2b_fd_count got=%0d want=3", fd_count); end
    total++; if (rd_when_empty !== 0) begin bad++; $display("FAIL b2b_rd_empty got=%0d want=0", rd_when_empty); end
    total++; if (unstable !== 0) begin bad++; $display("FAIL b2b_stable got=%0d want=0", unstable); end
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubbles();
    test_binarize();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_stream_packer.md
Name: edge_stream_packer

Overview:
Consumer end of the edge-detect output FIFO. Drains single-pixel Sobel results via the FIFO read handshake (empty/rd_en/dout), optionally binarizes them, and packs PACK pixels into one wide word. Words leave through a valid/ready port with raster framing flags (sof/eol/eof). It is the sink-side bridge between the pixel pipeline and a word-oriented writeback or DMA path.

Parameters:
DATA_WIDTH, 8, bits per pixel
IMAGE_WIDTH, 720, pixels per row; must be a multiple of PACK, otherwise elaboration error
IMAGE_HEIGHT, 540, rows per frame
PACK, 4, pixels per output word

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-low reset
in_empty  in  1  source FIFO empty
in_dout  in  DATA_WIDTH  source FIFO head data; show-ahead, valid whenever in_empty=0
in_rd_en  out  1  pop source FIFO; combinational
bin_en  in  1  binarize enable, sampled per pixel at pop
threshold  in  DATA_WIDTH  binarize threshold
out_valid  out  1  output word valid
out_ready  in  1  downstream accept
out_data  out  DATA_WIDTH*PACK  packed word; lane 0 (first pixel) in LSBs
out_sof  out  1  word holds pixel (row 0, col 0)
out_eol  out  1  word holds col IMAGE_WIDTH-1
out_eof  out  1  eol of row IMAGE_HEIGHT-1
frame_done  out  1  one-cycle pulse, cycle after the eof word is accepted

Behaviour:
- Reset (rst=0, async): out_valid, out_data, flags, frame_done, lane index, col, row all 0. Partial word discarded. in_rd_en is 0 during reset.
- Pack register: PACK lanes plus lane_idx in 0..PACK-1. Output register: word plus flags plus out_valid.
- Output FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL when a pop fills lane PACK-1.
  - FULL -> EMPTY on out_valid&&out_ready with no word completing in the same cycle.
  - FULL stays FULL when accept and completion coincide. The new word loads in the same cycle.
- stall = out_valid && !out_ready && lane_idx==PACK-1.
- in_rd_en = !in_empty && !stall && rst. Never asserted while empty. Never pops a pixel that has no lane to go into.
- Throughput: 1 pixel/cycle sustained with out_ready=1.
- Latency: the pop that fills lane PACK-1 makes out_valid=1 on the next edge.
- Pixel value stored: bin_en ? (in_dout >= threshold ? all-ones : 0) : in_dout. The comparison is unsigned.
- Position counters advance once per pop. col wraps IMAGE_WIDTH-1 -> 0 and then increments row. row wraps IMAGE_HEIGHT-1 -> 0.
- Flags are computed from the positions of the pixels in the word and latched with the word.
  - sof: lane 0 is (0,0).
  - eol: lane PACK-1 is at col IMAGE_WIDTH-1.
  - eof: eol && row==IMAGE_HEIGHT-1.
- While out_valid=1 && out_ready=0, out_data and all flags hold stable.
- frame_done = registered (out_valid && out_ready && out_eof).
- Frames are back-to-back: the first word of the next frame may follow the eof word with no gap cycle.
- Reset mid-frame: the next popped pixel is (0,0) and its word carries sof=1.

Decomposition:
- Package edge_stream_pkg: pixel_t (logic [DATA_WIDTH-1:0]), word_flags_t struct {sof, eol, eof}, PACK default, and a function binarize(pixel_t p, pixel_t th, logic en).
- Sub-module raster_pos_counter: col/row counters with wrap. Inputs: clk, rst, advance. Outputs: col, row, is_first, is_last_col, is_last_row. Shareable with other frame-aware blocks.

Test Plan (IMAGE_WIDTH=8, IMAGE_HEIGHT=2, PACK=4 unless noted):
- Reset test: hold rst=0 with in_empty=0 -> in_rd_en=0, out_valid=0, frame_done=0. Release -> the first pop occurs in the first cycle.
- Streaming: pixels 0x01..0x10, in_empty=0 throughout, out_ready=1 -> in_rd_en high for 16 consecutive cycles. Expected words:
  - 0x04030201 with sof=1.
  - 0x08070605 with eol=1.
  - 0x0C0B0A09.
  - 0x100F0E0D with eol=1, eof=1.
  - frame_done pulses once, the cycle after the last accept.
- Backpressure: same stream, out_ready=0 after word 1 is presented -> three more pops (lanes 0-2), then in_rd_en=0. Word 1 stays stable. Release -> words 2..4 follow in order, with no loss or duplication.
- Bubbles: in_empty toggles 0/1 every cycle -> in_rd_en is never 1 while in_empty=1. Output words and flags are identical to the streaming test.
- Binarize: bin_en=1, threshold=0x80, pixels 0x7F, 0x80, 0x81, 0x00 -> out_data=0x00FFFF00.
- Reset mid-frame: assert rst=0 after 6 pixels, then stream 0x21..0x24 -> out_data=0x24232221 with sof=1. No earlier partial word is ever emitted.
